// File: rtl/tc_work_dispatcher.sv
// tc_work_dispatcher
// Thread controller sitting between the scheduler node (SN) and one SIMD core
// plus one prefetch (PF) core. A request from SN names a work list (base
// address, item count). Every item is run on the SIMD core. While the SIMD
// core works on item i, the PF core is started on item i+1. When all items
// are finished, completion is reported back to SN.
//
// Work-list layout at base:
//   [base, base+GARG_BYTES)         global-argument block
//   L(i) = base + GARG_BYTES + i*LARG_BYTES   local-argument block of item i
// Address arithmetic wraps modulo 2^ADDR_WIDTH.
//
// Handshake contract (all outputs are registered):
//   SN side  : next_op is a level request that is sampled only in IDLE.
//              clr_next pulses for one cycle when the request is taken.
//              req_done pulses for one cycle when the whole list is finished.
//              next_op may be reasserted, or held, in the req_done cycle.
//   Core side: a core runs while its *_reset output is 0. It raises *_done
//              and holds it until *_reset returns to 1. The pointers for an
//              item are valid in the same cycle that its reset drops.
//              *_done is ignored outside RUN.
//
// dbg_state and dbg_idx expose the FSM state and the item counter. They exist
// so that checkers can bind to them.
module tc_work_dispatcher #(
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    WL_LEN_BITS    = 32,
  parameter int                    GARG_BYTES     = 64,
  parameter int                    LARG_BYTES     = 32,
  parameter logic [ADDR_WIDTH-1:0] SIMD_CODE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  // scheduler node interface
  input  logic                   next_op,
  input  logic [ADDR_WIDTH-1:0]  next_addr,
  input  logic [WL_LEN_BITS-1:0] next_len,
  output logic                   clr_next,
  output logic                   req_done,
  // SIMD core interface
  input  logic                   simd_done,
  output logic                   simd_reset,
  output logic [ADDR_WIDTH-1:0]  g_arg_pointer,
  output logic [ADDR_WIDTH-1:0]  l_arg_pointer,
  output logic [ADDR_WIDTH-1:0]  simd_ptr,
  // prefetch core interface
  input  logic                   pf_done,
  output logic                   pf_reset,
  output logic [ADDR_WIDTH-1:0]  pf_ptr,
  // debug visibility
  output logic [2:0]             dbg_state,
  output logic [WL_LEN_BITS-1:0] dbg_idx
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_LAUNCH  = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] GARG_OFS = ADDR_WIDTH'(GARG_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LARG_OFS = ADDR_WIDTH'(LARG_BYTES);

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [WL_LEN_BITS-1:0] len_q;
  logic [WL_LEN_BITS-1:0] idx_q;
  logic                   pf_busy_q;
  logic                   pf_ok_q;

  logic                   accept;
  logic                   run_exit;
  logic                   do_launch;
  logic                   has_next;
  logic [WL_LEN_BITS:0]   idx_plus1;
  logic [ADDR_WIDTH-1:0]  l_cur;
  logic [ADDR_WIDTH-1:0]  l_nxt;

  // Local-argument address of item i. The math is modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] item_addr(
    input logic [ADDR_WIDTH-1:0]  b,
    input logic [WL_LEN_BITS-1:0] i
  );
    return b + GARG_OFS + (ADDR_WIDTH'(i) * LARG_OFS);
  endfunction

  // Derived control terms. The item counter is extended by one bit, so idx+1
  // cannot overflow when len is at its maximum value.
  always_comb begin
    accept    = (state_q == ST_IDLE) && next_op;
    idx_plus1 = {1'b0, idx_q} + {{WL_LEN_BITS{1'b0}}, 1'b1};
    has_next  = idx_plus1 < {1'b0, len_q};
    l_cur     = item_addr(base_q, idx_q);
    l_nxt     = l_cur + LARG_OFS;
    // Leave RUN only when the SIMD core is done and any PF launched for this
    // item is done as well. A pf_done in the same cycle as simd_done counts.
    run_exit  = (state_q == ST_RUN) && simd_done &&
                (!pf_busy_q || pf_ok_q || pf_done);
    // Outputs are registered, so the launch values are loaded on the edge
    // into LAUNCH. That places them in the LAUNCH cycle itself. As a result,
    // simd_reset is high for only the single ADVANCE cycle between items.
    do_launch = ((state_q == ST_CHECK)   && (len_q != '0)) ||
                ((state_q == ST_ADVANCE) && (idx_q != len_q));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (next_op) state_d = ST_CHECK;
      ST_CHECK:   state_d = (len_q == '0) ? ST_DONE : ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_RUN;
      ST_RUN:     if (run_exit) state_d = ST_ADVANCE;
      ST_ADVANCE: state_d = (idx_q == len_q) ? ST_DONE : ST_LAUNCH;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: base, length and the fixed per-request pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q        <= '0;
      len_q         <= '0;
      g_arg_pointer <= '0;
      simd_ptr      <= '0;
    end else if (accept) begin
      base_q        <= next_addr;
      len_q         <= next_len;
      g_arg_pointer <= next_addr;
      simd_ptr      <= SIMD_CODE_ADDR;
    end
  end

  // Item counter. It advances on RUN exit, so idx never exceeds len.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
    end else if (run_exit) begin
      idx_q <= idx_plus1[WL_LEN_BITS-1:0];
    end
  end

  // SIMD core control: release on launch, force back into reset on RUN exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      simd_reset    <= 1'b1;
      l_arg_pointer <= '0;
    end else if (run_exit) begin
      simd_reset    <= 1'b1;
    end else if (do_launch) begin
      simd_reset    <= 1'b0;
      l_arg_pointer <= l_cur;
    end
  end

  // PF core control. PF is started on item idx+1 alongside the SIMD launch of
  // item idx, but only when that item exists. pf_ok records that the running
  // prefetch has finished. The flag persists through ADVANCE. A fresh
  // prefetch clears it, so RUN then waits for the new PF result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_reset  <= 1'b1;
      pf_ptr    <= '0;
      pf_busy_q <= 1'b0;
      pf_ok_q   <= 1'b0;
    end else begin
      if (accept) begin
        pf_busy_q <= 1'b0;
        pf_ok_q   <= 1'b0;
      end
      if ((state_q == ST_RUN) && pf_busy_q && pf_done) begin
        pf_ok_q <= 1'b1;
      end
      if (run_exit) begin
        pf_reset <= 1'b1;
      end
      if (state_q == ST_ADVANCE) begin
        pf_busy_q <= 1'b0;
      end
      if (do_launch && has_next) begin
        pf_reset  <= 1'b0;
        pf_ptr    <= l_nxt;
        pf_busy_q <= 1'b1;
        pf_ok_q   <= 1'b0;
      end
    end
  end

  // One-cycle SN pulses: request taken, request complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_next <= 1'b0;
      req_done <= 1'b0;
    end else begin
      clr_next <= accept;
      req_done <= (state_q == ST_DONE);
    end
  end

  assign dbg_state = state_q;
  assign dbg_idx   = idx_q;

endmodule

// File: tb/tb_tc_work_dispatcher.sv
// tb_tc_work_dispatcher
// Directed bench for tc_work_dispatcher. Each scenario task drives its own
// stimulus and compares the DUT outputs against hand-computed values.
module tb_tc_work_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        next_op;
  logic [63:0] next_addr;
  logic [31:0] next_len;
  logic        clr_next;
  logic        req_done;
  logic        simd_done;
  logic        simd_reset;
  logic [63:0] g_arg_pointer;
  logic [63:0] l_arg_pointer;
  logic [63:0] simd_ptr;
  logic        pf_done;
  logic        pf_reset;
  logic [63:0] pf_ptr;
  logic [2:0]  dbg_state;
  logic [31:0] dbg_idx;

  int errors = 0;
  int checks = 0;

  tc_work_dispatcher dut (
    .clk           (clk),
    .reset         (reset),
    .next_op       (next_op),
    .next_addr     (next_addr),
    .next_len      (next_len),
    .clr_next      (clr_next),
    .req_done      (req_done),
    .simd_done     (simd_done),
    .simd_reset    (simd_reset),
    .g_arg_pointer (g_arg_pointer),
    .l_arg_pointer (l_arg_pointer),
    .simd_ptr      (simd_ptr),
    .pf_done       (pf_done),
    .pf_reset      (pf_reset),
    .pf_ptr        (pf_ptr),
    .dbg_state     (dbg_state),
    .dbg_idx       (dbg_idx)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle. On return the DUT is in CHECK.
  task automatic start_op(input logic [63:0] a, input logic [31:0] n);
    next_addr = a;
    next_len  = n;
    next_op   = 1'b1;
    tick();
    next_op   = 1'b0;
  endtask

  // Core model for one item. It waits for the SIMD launch and records the
  // pointers. It raises simd_done after simd_lat RUN cycles and pf_done after
  // pf_lat RUN cycles (pf_lat is used only if PF was launched), then waits
  // for simd_reset to return high. run_cnt is the RUN-relative cycle in which
  // that is seen.
  task automatic serve_item(input int simd_lat, input int pf_lat,
                            output int wait_cnt, output logic [63:0] l_seen,
                            output logic [63:0] pf_seen, output logic pf_launched,
                            output int run_cnt);
    wait_cnt = 0;
    run_cnt  = 0;
    do begin
      tick();
      wait_cnt++;
    end while (simd_reset !== 1'b0 && wait_cnt < 20);
    l_seen      = l_arg_pointer;
    pf_seen     = pf_ptr;
    pf_launched = (pf_reset === 1'b0);
    if (simd_reset === 1'b0) begin
      for (int c = 1; c <= 100; c++) begin
        tick();
        run_cnt = c;
        if (simd_reset === 1'b1) break;
        if (c == simd_lat) simd_done = 1'b1;
        if (pf_launched && c == pf_lat) pf_done = 1'b1;
      end
    end
    simd_done = 1'b0;
    pf_done   = 1'b0;
  endtask

  // Wait for req_done, bounded. It also records whether either core was
  // released and how many clr_next pulses occurred along the way.
  task automatic wait_req_done(output int cyc, output int clr_cnt, output logic core_rel);
    cyc      = 0;
    clr_cnt  = 0;
    core_rel = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (simd_reset !== 1'b1 || pf_reset !== 1'b1) core_rel = 1'b1;
      if (clr_next === 1'b1) clr_cnt++;
      if (req_done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; next_op = 1'b0; next_addr = '0; next_len = '0;
    simd_done = 1'b0; pf_done = 1'b0;
    tick(); tick();
    checks++; if (simd_reset !== 1'b1) begin errors++; $display("FAIL reset_simd_reset: got %b expected 1", simd_reset); end
    checks++; if (pf_reset !== 1'b1) begin errors++; $display("FAIL reset_pf_reset: got %b expected 1", pf_reset); end
    checks++; if (clr_next !== 1'b0 || req_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got clr=%b done=%b expected 0 0", clr_next, req_done); end
    checks++; if ((l_arg_pointer | g_arg_pointer | pf_ptr | simd_ptr) !== 64'h0) begin errors++; $display("FAIL reset_pointers: got l=%h g=%h pf=%h s=%h expected 0", l_arg_pointer, g_arg_pointer, pf_ptr, simd_ptr); end
    checks++; if (dbg_state !== 3'd0 || dbg_idx !== 32'd0) begin errors++; $display("FAIL reset_state: got st=%0d idx=%0d expected 0 0", dbg_state, dbg_idx); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    simd_done = 1'b1; pf_done = 1'b1;
    tick(); tick(); tick();
    checks++; if (dbg_state !== 3'd0 || simd_reset !== 1'b1 || pf_reset !== 1'b1) begin errors++; $display("FAIL ignored_done_in_idle: got st=%0d sr=%b pr=%b expected 0 1 1", dbg_state, simd_reset, pf_reset); end
    simd_done = 1'b0; pf_done = 1'b0;
    tick();
  endtask

  task automatic test_len0();
    int cyc, clr_cnt; logic rel;
    start_op(64'h1000, 32'd0);
    checks++; if (clr_next !== 1'b1) begin errors++; $display("FAIL len0_clr_next: got %b expected 1", clr_next); end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL len0_done_latency: got %0d expected 2", cyc); end
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL len0_core_released: got %b expected 0", rel); end
    checks++; if (clr_cnt !== 0) begin errors++; $display("FAIL len0_clr_width: got %0d extra pulses expected 0", clr_cnt); end
    tick();
    checks++; if (req_done !== 1'b0) begin errors++; $display("FAIL len0_done_width: got %b expected 0", req_done); end
  endtask

  task automatic test_len1();
    int w, r, cyc, clr_cnt; logic [63:0] l, p; logic pl, rel;
    start_op(64'h1000, 32'd1);
    checks++; if (clr_next !== 1'b1) begin errors++; $display("FAIL len1_clr_next: got %b expected 1", clr_next); end
    serve_item(5, 0, w, l, p, pl, r);
    checks++; if (w !== 1) begin errors++; $display("FAIL len1_launch_latency: got %0d expected 1", w); end
    checks++; if (l !== 64'h1040) begin errors++; $display("FAIL len1_l_arg: got %h expected 1040", l); end
    checks++; if (g_arg_pointer !== 64'h1000) begin errors++; $display("FAIL len1_g_arg: got %h expected 1000", g_arg_pointer); end
    checks++; if (simd_ptr !== 64'h0) begin errors++; $display("FAIL len1_simd_ptr: got %h expected 0", simd_ptr); end
    checks++; if (pl !== 1'b0) begin errors++; $display("FAIL len1_pf_launched: got %b expected 0", pl); end
    checks++; if (r !== 6) begin errors++; $display("FAIL len1_run_exit: got %0d expected 6", r); end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL len1_done_latency: got %0d expected 2", cyc); end
    tick();
    checks++; if (req_done !== 1'b0) begin errors++; $display("FAIL len1_single_done: got %b expected 0", req_done); end
  endtask

  task automatic test_len3();
    logic [63:0] exp_l [3];
    logic [63:0] exp_pf [2];
    int w, r, cyc, clr_cnt; logic [63:0] l, p; logic pl, rel;
    exp_l[0] = 64'h2040; exp_l[1] = 64'h2060; exp_l[2] = 64'h2080;
    exp_pf[0] = 64'h2060; exp_pf[1] = 64'h2080;
    start_op(64'h2000, 32'd3);
    for (int i = 0; i < 3; i++) begin
      serve_item(3, 3, w, l, p, pl, r);
      checks++; if (w !== 1) begin errors++; $display("FAIL len3_reset_gap item%0d: got %0d expected 1", i, w); end
      checks++; if (l !== exp_l[i]) begin errors++; $display("FAIL len3_l_arg item%0d: got %h expected %h", i, l, exp_l[i]); end
      checks++; if (pl !== (i < 2)) begin errors++; $display("FAIL len3_pf_launched item%0d: got %b expected %b", i, pl, (i < 2)); end
      if (i < 2) begin
        checks++; if (p !== exp_pf[i]) begin errors++; $display("FAIL len3_pf_ptr item%0d: got %h expected %h", i, p, exp_pf[i]); end
      end
      checks++; if (r !== 4) begin errors++; $display("FAIL len3_run_exit item%0d: got %0d expected 4", i, r); end
    end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL len3_done_latency: got %0d expected 2", cyc); end
    tick();
  endtask

  task automatic test_pf_slow();
    int w, r, cyc, clr_cnt; logic [63:0] l, p; logic pl, rel;
    start_op(64'h4000, 32'd2);
    serve_item(3, 10, w, l, p, pl, r);
    checks++; if (pl !== 1'b1) begin errors++; $display("FAIL pfslow_pf_launched: got %b expected 1", pl); end
    checks++; if (r !== 11) begin errors++; $display("FAIL pfslow_wait_pf: got exit at %0d expected 11", r); end
    serve_item(2, 0, w, l, p, pl, r);
    checks++; if (w !== 1) begin errors++; $display("FAIL pfslow_relaunch: got %0d expected 1", w); end
    checks++; if (l !== 64'h4060) begin errors++; $display("FAIL pfslow_l_arg: got %h expected 4060", l); end
    checks++; if (pl !== 1'b0) begin errors++; $display("FAIL pfslow_last_pf: got %b expected 0", pl); end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL pfslow_done_latency: got %0d expected 2", cyc); end
    tick();
  endtask

  task automatic test_reset_mid();
    int w, r, cyc, clr_cnt, n; logic [63:0] l, p; logic pl, rel, saw_done;
    start_op(64'h3000, 32'd4);
    serve_item(2, 2, w, l, p, pl, r);
    n = 0;
    do begin tick(); n++; end while (simd_reset !== 1'b0 && n < 20);
    tick(); tick();
    checks++; if (dbg_state !== 3'd3 || dbg_idx !== 32'd1) begin errors++; $display("FAIL mid_in_run: got st=%0d idx=%0d expected 3 1", dbg_state, dbg_idx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (simd_reset !== 1'b1 || pf_reset !== 1'b1) begin errors++; $display("FAIL mid_cores_reset: got sr=%b pr=%b expected 1 1", simd_reset, pf_reset); end
    checks++; if ((l_arg_pointer | g_arg_pointer | pf_ptr) !== 64'h0) begin errors++; $display("FAIL mid_pointers: got l=%h g=%h pf=%h expected 0", l_arg_pointer, g_arg_pointer, pf_ptr); end
    checks++; if (dbg_state !== 3'd0 || dbg_idx !== 32'd0) begin errors++; $display("FAIL mid_state: got st=%0d idx=%0d expected 0 0", dbg_state, dbg_idx); end
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (req_done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_req_done: got %b expected 0", saw_done); end
    start_op(64'h5000, 32'd1);
    serve_item(1, 0, w, l, p, pl, r);
    checks++; if (l !== 64'h5040 || r !== 2) begin errors++; $display("FAIL mid_new_op: got l=%h exit=%0d expected 5040 2", l, r); end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL mid_new_done: got %0d expected 2", cyc); end
    tick();
  endtask

  task automatic test_wrap();
    int w, r, cyc, clr_cnt; logic [63:0] l, p; logic pl, rel;
    start_op(64'hFFFF_FFFF_FFFF_FFB0, 32'd2);
    serve_item(1, 1, w, l, p, pl, r);
    checks++; if (l !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL wrap_l_arg0: got %h expected fffffffffffffff0", l); end
    checks++; if (pl !== 1'b1 || p !== 64'h10) begin errors++; $display("FAIL wrap_pf_ptr: got pl=%b p=%h expected 1 10", pl, p); end
    checks++; if (g_arg_pointer !== 64'hFFFF_FFFF_FFFF_FFB0) begin errors++; $display("FAIL wrap_g_arg: got %h expected ffffffffffffffb0", g_arg_pointer); end
    serve_item(1, 0, w, l, p, pl, r);
    checks++; if (l !== 64'h10) begin errors++; $display("FAIL wrap_l_arg1: got %h expected 10", l); end
    wait_req_done(cyc, clr_cnt, rel);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wrap_done_latency: got %0d expected 2", cyc); end
    tick();
  endtask

  task automatic test_back_to_back();
    int clr_cnt, done_cnt; logic clr_at4;
    clr_cnt = 0; done_cnt = 0; clr_at4 = 1'b0;
    next_addr = 64'h6000; next_len = 32'd0; next_op = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (clr_next === 1'b1) clr_cnt++;
      if (req_done === 1'b1) done_cnt++;
      if (c == 4) clr_at4 = clr_next;
    end
    next_op = 1'b0;
    checks++; if (clr_cnt !== 2) begin errors++; $display("FAIL b2b_clr_count: got %0d expected 2", clr_cnt); end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (clr_at4 !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got %b expected 1", clr_at4); end
    tick(); tick();
    checks++; if (clr_next !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL b2b_quiet: got clr=%b st=%0d expected 0 0", clr_next, dbg_state); end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ignored();
    test_len0();
    test_len1();
    test_len3();
    test_pf_slow();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
